// File: rtl/hypot_rr_scheduler.sv
// Round-robin shared floor(sqrt(x^2+y^2)) engine; result valid W+2 edges after accept, one op per W+4 cycles.
// Backpressure: a held result stalls the engine in DONE indefinitely and keeps every req_ready low.
module hypot_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*W-1:0] req_y,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W:0]        res_data,
    output logic [IDW-1:0]    res_id,
    output logic              busy
);

    localparam int SW  = 2 * W + 2;  // sum padded to an even width so each step eats two bits
    localparam int RW  = W + 2;      // remainder never exceeds 2*root
    localparam int RSW = W + 4;

    typedef enum logic [1:0] {S_IDLE, S_SQ, S_ROOT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [W-1:0]     x_q, x_d, y_q, y_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [SW-1:0]    sum_q, sum_d;
    logic [W:0]       root_q, root_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [W:0]       res_data_q, res_data_d;
    logic [IDW-1:0]   res_id_q, res_id_d;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   gid;
    logic [IDW-1:0]   cand;
    logic             found;
    logic [W-1:0]     x_sel, y_sel;
    logic [RSW-1:0]   rem_sh, trial;

    // Search from ptr upward with wrap; first valid requester wins.
    always_comb begin
        grant = '0;
        gid   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                grant[cand] = 1'b1;
                gid         = cand;
                found       = 1'b1;
            end
        end
    end

    always_comb begin
        x_sel = '0;
        y_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gid == IDW'(i)) begin
                x_sel = req_x[i*W +: W];
                y_sel = req_y[i*W +: W];
            end
        end
    end

    assign req_ready = (rst_n && state_q == S_IDLE) ? grant : '0;
    assign res_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        x_d        = x_q;
        y_d        = y_q;
        id_d       = id_q;
        sum_d      = sum_q;
        root_d     = root_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        res_id_d   = res_id_q;
        rem_sh     = '0;
        trial      = '0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    x_d     = x_sel;
                    y_d     = y_sel;
                    id_d    = gid;
                    ptr_d   = IDW'((int'(gid) + 1) % NREQ);
                    state_d = S_SQ;
                end
            end
            S_SQ: begin
                sum_d   = SW'(x_q) * SW'(x_q) + SW'(y_q) * SW'(y_q);
                root_d  = '0;
                rem_d   = '0;
                cnt_d   = '0;
                state_d = S_ROOT;
            end
            S_ROOT: begin
                // Restoring step: try subtracting 4*root+1 from the widened remainder.
                rem_sh = {rem_q, sum_q[SW-1 -: 2]};
                trial  = RSW'({root_q, 2'b01});
                if (rem_sh >= trial) begin
                    rem_d  = RW'(rem_sh - trial);
                    root_d = {root_q[W-1:0], 1'b1};
                end else begin
                    rem_d  = RW'(rem_sh);
                    root_d = {root_q[W-1:0], 1'b0};
                end
                sum_d = sum_q << 2;
                if (cnt_q == 4'(W)) begin
                    res_data_d = root_d;
                    res_id_d   = id_q;
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            id_q       <= '0;
            sum_q      <= '0;
            root_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            res_data_q <= '0;
            res_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            x_q        <= x_d;
            y_q        <= y_d;
            id_q       <= id_d;
            sum_q      <= sum_d;
            root_q     <= root_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
        end
    end

endmodule

// File: tb/tb_hypot_rr_scheduler.sv
// Scoreboard bench for hypot_rr_scheduler: grant model, result queue, latency and backpressure checks.
module tb_hypot_rr_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic            clk;
    logic            rst_n;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic            res_valid;
    logic            res_ready;
    logic [W:0]      res_data;
    logic [1:0]      res_id;
    logic            busy;

    typedef struct {
        int id;
        int data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   ptr_m = 0;
    int   busy_exp = 0;
    int   acc_cyc = 0;
    logic rv_prev = 1'b0;

    hypot_rr_scheduler #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int isqrt(input int v);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Reference model of the engine as seen from its ports, evaluated mid-cycle.
    always @(negedge clk) begin : mon
        int   bn;
        int   eg;
        int   gi;
        int   xv;
        int   yv;
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            ptr_m    = 0;
            busy_exp = 0;
            rv_prev  = 1'b0;
        end else begin
            bn = busy_exp;
            chk("busy", int'(busy), busy_exp);
            chk("onehot", int'($countones(req_ready) <= 1), 1);
            if (busy_exp != 0) begin
                chk("rdy_quiet", int'(req_ready), 0);
            end else begin
                gi = -1;
                for (int k = 0; k < NREQ; k++) begin
                    int c;
                    c = (ptr_m + k) % NREQ;
                    if (gi < 0 && req_valid[c]) gi = c;
                end
                eg = (gi >= 0) ? (1 << gi) : 0;
                chk("grant", int'(req_ready), eg);
                if (gi >= 0) begin
                    xv = int'(req_x[gi*W +: W]);
                    yv = int'(req_y[gi*W +: W]);
                    sb.push_back('{gi, isqrt(xv * xv + yv * yv)});
                    ptr_m   = (gi + 1) % NREQ;
                    acc_cyc = cyc;
                    bn      = 1;
                end
            end
            if (res_valid && !rv_prev) chk("latency", cyc - acc_cyc, 11);
            if (res_valid) begin
                if (sb.size() == 0) begin
                    chk("res_unexpected", 1, 0);
                end else begin
                    chk("res_data", int'(res_data), sb[0].data);
                    chk("res_id", int'(res_id), sb[0].id);
                    if (res_ready) begin
                        e  = sb.pop_front();
                        bn = 0;
                    end
                end
            end
            rv_prev  = res_valid;
            busy_exp = bn;
        end
    end

    task automatic wait_grant(output int g);
        g = -1;
        for (int n = 0; n < 100 && g < 0; n++) begin
            @(negedge clk);
            for (int k = 0; k < NREQ; k++) if (req_ready[k]) g = k;
        end
        if (g < 0) chk("grant_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && busy_exp == 0) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 0, 1);
    endtask

    task automatic set_ops(input int i, input int x, input int y);
        req_x[i*W +: W] = W'(x);
        req_y[i*W +: W] = W'(y);
    endtask

    task automatic do_op(input int i, input int x, input int y);
        int g;
        @(posedge clk);
        #1;
        set_ops(i, x, y);
        req_valid[i] = 1'b1;
        wait_grant(g);
        chk("op_grant", g, i);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
        wait_drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation watchdog expired");
    end

    initial begin : stim
        int g;
        int seen;
        rst_n     = 1'b1;
        req_valid = 4'b0001;
        req_x     = '0;
        req_y     = '0;
        res_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_data", int'(res_data), 0);
        chk("rst_res_id", int'(res_id), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n     = 1'b1;
        req_valid = '0;

        // Single op, exact triples, bounds (last on req3 leaves ptr at 0)
        do_op(0, 3, 4);
        do_op(1, 20, 99);
        do_op(0, 6, 8);
        do_op(2, 5, 12);
        do_op(1, 0, 0);
        do_op(2, 255, 255);
        do_op(0, 255, 0);
        do_op(3, 1, 1);

        // Contention: all four, then only 1 and 3
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) set_ops(i, $urandom_range(0, 255), $urandom_range(0, 255));
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            wait_grant(g);
            chk("rr_order", g, k % 4);
            @(posedge clk);
            #1;
            if (g >= 0) set_ops(g, $urandom_range(0, 255), $urandom_range(0, 255));
            if (k == 7) req_valid = 4'b1010;
        end
        for (int k = 0; k < 4; k++) begin
            wait_grant(g);
            chk("alt_order", g, (k % 2 == 0) ? 1 : 3);
            @(posedge clk);
            #1;
            if (g >= 0) set_ops(g, $urandom_range(0, 255), $urandom_range(0, 255));
            if (k == 3) req_valid = '0;
        end
        wait_drain();

        // Backpressure with another requester waiting
        res_ready = 1'b0;
        @(posedge clk);
        #1;
        set_ops(2, 5, 12);
        req_valid[2] = 1'b1;
        wait_grant(g);
        chk("bp_grant", g, 2);
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        set_ops(1, 7, 24);
        req_valid[1] = 1'b1;
        seen = 0;
        for (int n = 0; n < 50 && seen == 0; n++) begin
            @(negedge clk);
            if (res_valid) seen = 1;
        end
        chk("bp_res_seen", seen, 1);
        repeat (6) begin
            @(negedge clk);
            chk("bp_hold_valid", int'(res_valid), 1);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_handshake", int'(res_valid & res_ready), 1);
        @(negedge clk);
        chk("bp_accept_next", int'(req_ready), 4'b0010);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        wait_drain();

        // Reset in the middle of ROOT
        @(posedge clk);
        #1;
        set_ops(3, 200, 100);
        req_valid[3] = 1'b1;
        wait_grant(g);
        chk("mid_grant", g, 3);
        @(posedge clk);
        #1;
        req_valid[3] = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n     = 1'b0;
        req_valid = 4'b0001;
        #1;
        chk("mid_rst_res_valid", int'(res_valid), 0);
        chk("mid_rst_res_data", int'(res_data), 0);
        chk("mid_rst_res_id", int'(res_id), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_req_ready", int'(req_ready), 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        set_ops(0, 9, 12);
        set_ops(2, 1, 2);
        req_valid = 4'b0101;
        @(negedge clk);
        chk("post_rst_grant", int'(req_ready), 4'b0001);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_drain();
        repeat (15) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
